// File: rtl/alu3_bcd_pkg.sv
// Shared constants for the 3-bit BCD ALU: operation selects and output codes.
package alu3_bcd_pkg;

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_MUL = 2'd2;
  localparam logic [1:0] MODE_DIV = 2'd3;

  // Tens-nibble marker for a negative subtract result.
  localparam logic [3:0] BCD_MINUS = 4'hF;
  // Full-byte marker for divide by zero.
  localparam logic [7:0] DIV0_CODE = 8'hEE;

endpackage

// File: rtl/alu3_bcd_bin6_to_bcd.sv
// 6-bit binary (0..63) to two packed BCD digits using shift-add-3.
module bin6_to_bcd (
  input  logic [5:0] bin,
  output logic [7:0] bcd
);

  logic [13:0] scratch;

  // Double dabble: correct each BCD column before every shift.
  always_comb begin
    scratch = {8'd0, bin};
    for (int i = 0; i < 6; i++) begin
      if (scratch[9:6] >= 4'd5)   scratch[9:6]   = scratch[9:6] + 4'd3;
      if (scratch[13:10] >= 4'd5) scratch[13:10] = scratch[13:10] + 4'd3;
      scratch = scratch << 1;
    end
    bcd = scratch[13:6];
  end

endmodule

// File: rtl/alu3_bcd.sv
// Registered 3-bit ALU (add/sub/mul/div) with a packed two-digit BCD result.
module alu3_bcd
  import alu3_bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] left,
  input  logic [2:0] right,
  input  logic [1:0] mode,
  output logic [7:0] data
);

  logic [3:0] sum;
  logic       neg;
  logic [2:0] mag;
  logic [5:0] prod;
  logic [5:0] conv_in;
  logic [7:0] conv_out;
  logic [3:0] quo;
  logic [2:0] rem;
  logic [7:0] next_data;

  assign sum  = {1'b0, left} + {1'b0, right};
  assign neg  = left < right;
  assign mag  = neg ? (right - left) : (left - right);
  assign prod = {3'b000, left} * {3'b000, right};

  // One shared converter; the mode picks which binary value it sees.
  always_comb begin
    case (mode)
      MODE_ADD: conv_in = {2'b00, sum};
      MODE_SUB: conv_in = {3'b000, mag};
      MODE_MUL: conv_in = prod;
      default:  conv_in = 6'd0;
    endcase
  end

  bin6_to_bcd u_bin6_to_bcd (
    .bin (conv_in),
    .bcd (conv_out)
  );

  // Divide by repeated subtraction; seven steps cover the worst case 7/1.
  always_comb begin
    rem = left;
    quo = 4'd0;
    for (int i = 0; i < 7; i++) begin
      if (right != 3'd0 && rem >= right) begin
        rem = rem - right;
        quo = quo + 4'd1;
      end
    end
  end

  // Result mux including the minus and divide-by-zero codes.
  always_comb begin
    case (mode)
      MODE_SUB: next_data = neg ? {BCD_MINUS, conv_out[3:0]} : conv_out;
      MODE_DIV: next_data = (right == 3'd0) ? DIV0_CODE : {quo, 1'b0, rem};
      default:  next_data = conv_out;
    endcase
  end

  // Output register; reset clears it immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data <= 8'h00;
    else       data <= next_data;
  end

endmodule

// File: tb/tb_alu3_bcd.sv
// Scoreboard bench for alu3_bcd: stimulus queues expected results, monitor checks them.
module tb_alu3_bcd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] left = 3'd0;
  logic [2:0] right = 3'd0;
  logic [1:0] mode = 2'd0;
  logic [7:0] data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] exp;
    logic [2:0] l;
    logic [2:0] r;
    logic [1:0] m;
  } item_t;

  item_t exp_q[$];

  alu3_bcd dut (
    .clk   (clk),
    .reset (reset),
    .left  (left),
    .right (right),
    .mode  (mode),
    .data  (data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dec2(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic [7:0] ref_result(input int l, input int r, input int m);
    case (m)
      0: return dec2(l + r);
      1: begin
        if (l >= r) return dec2(l - r);
        else return {4'hF, 4'(r - l)};
      end
      2: return dec2(l * r);
      default: begin
        if (r == 0) return 8'hEE;
        else return {4'(l / r), 4'(l % r)};
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] l, input logic [2:0] r, input logic [1:0] m,
                       input logic [7:0] e);
    item_t it;
    @(negedge clk);
    left = l;
    right = r;
    mode = m;
    it.exp = e;
    it.l = l;
    it.r = r;
    it.m = m;
    exp_q.push_back(it);
  endtask

  // Monitor: one result per edge for each queued operation.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        check($sformatf("op l=%0d r=%0d m=%0d", it.l, it.r, it.m), data, it.exp);
        if (data !== 8'hEE) begin
          checks++;
          if (data[3:0] > 4'd9 || (data[7:4] > 4'd9 && data[7:4] != 4'hF)) begin
            failures++;
            $display("FAIL bcd_valid l=%0d r=%0d m=%0d: got %h required valid digits",
                     it.l, it.r, it.m, data);
          end
        end
      end
    end
  end

  initial begin
    #7;
    check("reset_state", data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_release_no_edge", data, 8'h00);

    issue(3'd7, 3'd5, 2'd0, 8'h12);
    issue(3'd7, 3'd5, 2'd1, 8'h02);
    issue(3'd7, 3'd5, 2'd2, 8'h35);
    issue(3'd7, 3'd5, 2'd3, 8'h12);
    issue(3'd3, 3'd6, 2'd1, 8'hF3);
    issue(3'd6, 3'd6, 2'd1, 8'h00);
    issue(3'd7, 3'd7, 2'd2, 8'h49);
    issue(3'd0, 3'd7, 2'd2, 8'h00);
    issue(3'd7, 3'd7, 2'd0, 8'h14);
    issue(3'd4, 3'd0, 2'd3, 8'hEE);
    issue(3'd2, 3'd7, 2'd3, 8'h02);
    issue(3'd0, 3'd0, 2'd3, 8'hEE);
    issue(3'd0, 3'd7, 2'd1, 8'hF7);
    issue(3'd7, 3'd1, 2'd3, 8'h70);

    // Reset asserted between edges while data holds 0x35.
    issue(3'd7, 3'd5, 2'd2, 8'h35);
    @(posedge clk);
    #3;
    reset = 1'b1;
    // New operand change while in reset must not leak through.
    left = 3'd7;
    right = 3'd7;
    mode = 2'd2;
    #1;
    check("async_reset_clear", data, 8'h00);
    @(posedge clk);
    #1;
    check("reset_held_edge", data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_waits_edge", data, 8'h00);
    begin
      item_t it;
      it.exp = 8'h49;
      it.l = 3'd7;
      it.r = 3'd7;
      it.m = 2'd2;
      exp_q.push_back(it);
    end

    // Exhaustive sweep against the decimal reference model.
    for (int m = 0; m < 4; m++)
      for (int l = 0; l < 8; l++)
        for (int r = 0; r < 8; r++)
          issue(3'(l), 3'(r), 2'(m), ref_result(l, r, m));

    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
